// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: controller state encoding and the
// output-mux select codes understood by the TX datapath.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   localparam logic [1:0] TX_OUT_SPACE  = 2'b00;
   localparam logic [1:0] TX_OUT_MARK   = 2'b01;
   localparam logic [1:0] TX_OUT_DATA   = 2'b10;
   localparam logic [1:0] TX_OUT_PARITY = 2'b11;

endpackage

// File: rtl/uart_tx_controller.sv
// Frame-sequencing FSM for the UART transmitter: turns baud ticks into the
// control strobes and line select that drive the TX datapath.
module uart_tx_controller
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       parity_en,
   input  logic       stop_bits,
   input  logic       tx_queue_empty,
   input  logic       tx_bits_cnt_top,
   output logic       tx_queue_re,
   output logic       tx_shift_reg_we,
   output logic       tx_shift_reg_se,
   output logic       tx_shift_reg_reset,
   output logic [1:0] tx_out_sel,
   output logic       tx_bits_cnt_en,
   output logic       tx_bits_cnt_reset,
   output logic       tx_parity_we,
   output logic       tx_parity_reset,
   output logic       busy
);

   tx_state_t state, state_next;
   logic      stop2, stop2_next;
   logic      parity_cfg, stop_cfg;
   logic      load;
   logic      step;

   // Frame options are captured only when a new byte is loaded, so the
   // register block may change them at any time without corrupting a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= TX_IDLE;
         stop2      <= 1'b0;
         parity_cfg <= 1'b0;
         stop_cfg   <= 1'b0;
      end else begin
         state <= state_next;
         stop2 <= stop2_next;
         if (load) begin
            parity_cfg <= parity_en;
            stop_cfg   <= stop_bits;
         end
      end
   end

   // Strobes are gated by reset as well as tick so nothing fires while the
   // block is being held in reset.
   assign step = tick & reset_n;

   always_comb begin
      state_next         = state;
      stop2_next         = stop2;
      load               = 1'b0;
      tx_queue_re        = 1'b0;
      tx_shift_reg_we    = 1'b0;
      tx_shift_reg_se    = 1'b0;
      tx_shift_reg_reset = 1'b0;
      tx_out_sel         = TX_OUT_MARK;
      tx_bits_cnt_en     = 1'b0;
      tx_bits_cnt_reset  = 1'b0;
      tx_parity_we       = 1'b0;
      tx_parity_reset    = 1'b0;
      busy               = 1'b1;

      case (state)
         TX_IDLE: begin
            busy = 1'b0;
            if (step && !tx_queue_empty) begin
               load = 1'b1;
            end
            tx_shift_reg_reset = !load;
         end
         TX_START: begin
            tx_out_sel = TX_OUT_SPACE;
            if (step) begin
               state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            tx_out_sel = TX_OUT_DATA;
            if (step) begin
               tx_parity_we   = 1'b1;
               tx_bits_cnt_en = 1'b1;
               if (tx_bits_cnt_top) begin
                  state_next = parity_cfg ? TX_PARITY : TX_STOP;
               end else begin
                  tx_shift_reg_se = 1'b1;
               end
            end
         end
         TX_PARITY: begin
            tx_out_sel = TX_OUT_PARITY;
            if (step) begin
               state_next = TX_STOP;
            end
         end
         TX_STOP: begin
            if (step) begin
               if (stop_cfg && !stop2) begin
                  stop2_next = 1'b1;
               end else if (!tx_queue_empty) begin
                  load = 1'b1;
               end else begin
                  state_next = TX_IDLE;
               end
            end
         end
         default: begin
            state_next = TX_IDLE;
         end
      endcase

      // A load from IDLE or from the end of a stop period behaves identically,
      // which is what allows back-to-back frames with no idle gap.
      if (load) begin
         tx_queue_re       = 1'b1;
         tx_shift_reg_we   = 1'b1;
         tx_bits_cnt_reset = 1'b1;
         tx_parity_reset   = 1'b1;
         stop2_next        = 1'b0;
         state_next        = TX_START;
      end
   end

endmodule
